pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage in-order core (IF/ID/EX/MEM/WB). It combines the ID-stage load-use stall, the ID-stage branch/jump redirect, the instruction-fetch handshake and the MEM-stage load/store handshake. From these it drives per-stage write-enable and flush/bubble controls for the PC and the four pipeline registers. A small FSM handles multi-cycle memory waits and discards the wrong-path fetch that is still in flight when a redirect occurs.

Parameters:
TMO_W, 8, width of the MEM-wait watchdog counter
MEM_TIMEOUT, 200, MEM-wait cycles after which mem_timeout sets; must be less than 2^TMO_W

Ports:
clock  in  1  core clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
id_stall  in  1  load-use hazard from ID (EX holds a load whose rd matches an ID source)
id_jump  in  1  ID resolved a taken branch/jump; PC mux selects the branch target
ifu_busy  in  1  a fetch request is outstanding and not yet returned
ifu_valid  in  1  fetched instruction presented to IF/ID this cycle
lsu_req  in  1  MEM stage holds a load/store request
lsu_done  in  1  LSU completes the current request this cycle
pc_we  out  1  PC register update enable
if_id_we  out  1  IF/ID register write enable
if_id_flush  out  1  load NOP into IF/ID (overrides if_id_we)
id_ex_we  out  1  ID/EX register write enable
id_ex_flush  out  1  load NOP into ID/EX (overrides id_ex_we)
ex_mem_we  out  1  EX/MEM register write enable
mem_wb_we  out  1  MEM/WB register write enable
mem_wb_bubble  out  1  load NOP into MEM/WB (overrides mem_wb_we)
mem_timeout  out  1  sticky error: MEM wait exceeded MEM_TIMEOUT
state_o  out  2  current FSM state, for debug

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low. Port names are clock and reset.
- Reset (sampled low at an edge):
  - state to RUN, drop_pend to 0, tmo_cnt to 0, mem_timeout to 0.
  - While reset is low, all *_we are 0 and all flush/bubble outputs are 1, regardless of state.
- FSM states: RUN=2'd0, MEM_WAIT=2'd1, DROP=2'd2. 2'd3 is illegal and recovers to RUN next cycle with RUN outputs.
- Control outputs are combinational from inputs, state and drop_pend, valid in the same cycle. Priority, highest first:
  - P1, mem_hold = lsu_req & ~lsu_done (any state):
    - pc_we = if_id_we = id_ex_we = ex_mem_we = 0.
    - mem_wb_bubble = 1, so WB never retires twice.
  - P2, id_stall:
    - pc_we = if_id_we = 0.
    - id_ex_flush = 1.
    - ex_mem_we = mem_wb_we = 1.
    - id_jump is ignored this cycle.
  - P3, id_jump:
    - pc_we = 1, if_id_flush = 1.
    - All other stages advance.
  - P4, fetch not ready (~ifu_valid), or ifu_valid while drop_pend = 1:
    - pc_we = 0 on ~ifu_valid; pc_we = 1 when the returning instruction is being dropped.
    - if_id_flush = 1; downstream stages advance.
  - Otherwise all *_we = 1 and all flushes are 0.
- Transitions:
  - RUN to MEM_WAIT: on mem_hold. tmo_cnt loads 1.
  - MEM_WAIT: stays while mem_hold, incrementing tmo_cnt (saturating at all-ones). Exits to RUN on lsu_done, or to DROP if drop_pend = 1.
  - A cycle with id_jump honoured (P3) while ifu_busy = 1 sets drop_pend and moves to DROP.
  - DROP: the next ifu_valid is discarded (P4 drop), drop_pend clears, and the state returns to RUN.
  - A new honoured id_jump in DROP keeps drop_pend set (only one fetch is ever outstanding).
  - lsu_req with lsu_done in the same cycle is not a hold and costs zero cycles.
- Watchdog:
  - mem_timeout sets when tmo_cnt reaches MEM_TIMEOUT in MEM_WAIT.
  - It stays set until reset; it does not alter pipeline control.

Optional Feature:
PIPE_CTRL_PERF_EN:
- Defined: adds outputs perf_stall_cnt[31:0] (cycles with pc_we = 0 outside reset) and perf_flush_cnt[31:0] (cycles with if_id_flush or id_ex_flush = 1 outside reset).
  - Both counters wrap modulo 2^32 and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset held low 3 cycles, then high with ifu_valid = 1 and all other inputs 0 -> during reset all *_we = 0 and all flushes = 1; the first cycle after release has all *_we = 1 and state_o = 0.
- id_stall = 1 for 1 cycle -> pc_we = 0, if_id_we = 0, id_ex_flush = 1, ex_mem_we = 1; the next cycle returns to full advance.
- id_stall = 1 and id_jump = 1 in the same cycle -> the stall wins (pc_we = 0, if_id_flush = 0); id_jump the next cycle gives pc_we = 1, if_id_flush = 1.
- lsu_req = 1 with lsu_done low for 4 cycles -> state_o = 1, all upstream *_we = 0, mem_wb_bubble = 1 for 4 cycles; lsu_done gives state_o = 0 the next cycle.
- id_jump with ifu_busy = 1, then ifu_valid 2 cycles later -> state_o = 2; the returning instruction is flushed (if_id_flush = 1, pc_we = 1); state_o = 0 afterwards.
- MEM_TIMEOUT = 5 with lsu_req held and lsu_done low for 6 cycles -> mem_timeout rises after the 5th wait cycle and stays high after lsu_done.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline sequencer and the datapath.
// Carries hazard/fetch/LSU status in and per-stage register controls out.
// master: the sequencer (pipe_hazard_ctrl); slave: the pipeline datapath.
interface pipe_hazard_ctrl_if;
    logic       id_stall;
    logic       id_jump;
    logic       ifu_busy;
    logic       ifu_valid;
    logic       lsu_req;
    logic       lsu_done;
    logic       pc_we;
    logic       if_id_we;
    logic       if_id_flush;
    logic       id_ex_we;
    logic       id_ex_flush;
    logic       ex_mem_we;
    logic       mem_wb_we;
    logic       mem_wb_bubble;
    logic       mem_timeout;
    logic [1:0] state_o;

    modport master (
        input  id_stall, id_jump, ifu_busy, ifu_valid,
        input  lsu_req, lsu_done,
        output pc_we, if_id_we, if_id_flush,
        output id_ex_we, id_ex_flush, ex_mem_we,
        output mem_wb_we, mem_wb_bubble,
        output mem_timeout, state_o
    );

    modport slave (
        output id_stall, id_jump, ifu_busy, ifu_valid,
        output lsu_req, lsu_done,
        input  pc_we, if_id_we, if_id_flush,
        input  id_ex_we, id_ex_flush, ex_mem_we,
        input  mem_wb_we, mem_wb_bubble,
        input  mem_timeout, state_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: PC/IF-ID/ID-EX/EX-MEM/MEM-WB enables and flushes.
// Ports: clock, reset (sync, active-low), hz (pipe_hazard_ctrl_if.master).
// Optional PIPE_CTRL_PERF_EN adds perf_stall_cnt/perf_flush_cnt outputs.
module pipe_hazard_ctrl #(
    parameter int TMO_W       = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic               clock,
    input  logic               reset,
    pipe_hazard_ctrl_if.master hz
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DROP     = 2'd2,
        ILL      = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             drop_pend_q, drop_pend_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;

    logic mem_hold;
    logic pend;
    logic jump_ok;
    logic drop_now;

    logic pc_we, if_id_we, if_id_flush;
    logic id_ex_we, id_ex_flush, ex_mem_we;
    logic mem_wb_we, mem_wb_bubble;

    // The illegal encoding behaves like RUN, so ignore any stale pending drop.
    assign mem_hold = hz.lsu_req & ~hz.lsu_done;
    assign pend     = drop_pend_q & (state_q != ILL);
    assign jump_ok  = ~mem_hold & ~hz.id_stall & hz.id_jump;
    assign drop_now = ~mem_hold & ~hz.id_stall & ~hz.id_jump
                    & hz.ifu_valid & pend;

    always_comb begin
        pc_we         = 1'b1;
        if_id_we      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_we      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_we     = 1'b1;
        mem_wb_we     = 1'b1;
        mem_wb_bubble = 1'b0;
        if (!reset) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_we      = 1'b0;
            id_ex_flush   = 1'b1;
            ex_mem_we     = 1'b0;
            mem_wb_we     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (mem_hold) begin
            // Freeze everything up to MEM; WB gets a NOP so it retires once.
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_we     = 1'b0;
            mem_wb_we     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (hz.id_stall) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (hz.id_jump) begin
            if_id_flush = 1'b1;
        end else if (!hz.ifu_valid || pend) begin
            // A dropped wrong-path word still consumes its PC slot.
            pc_we       = hz.ifu_valid;
            if_id_flush = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        drop_pend_d   = drop_pend_q;
        tmo_cnt_d     = tmo_cnt_q;
        mem_timeout_d = mem_timeout_q;
        if (state_q == ILL) begin
            state_d     = RUN;
            drop_pend_d = 1'b0;
            tmo_cnt_d   = '0;
        end else if (mem_hold) begin
            state_d = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                tmo_cnt_d = TMO_W'(1);
            end else if (tmo_cnt_q != '1) begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
            if (tmo_cnt_d >= TMO_W'(MEM_TIMEOUT)) begin
                mem_timeout_d = 1'b1;
            end
        end else begin
            tmo_cnt_d = '0;
            // A jump while an old fetch is still pending keeps one drop owed
            // unless that old fetch is returning right now.
            if (jump_ok) begin
                drop_pend_d = hz.ifu_busy | (drop_pend_q & ~hz.ifu_valid);
            end else if (drop_now) begin
                drop_pend_d = 1'b0;
            end
            state_d = drop_pend_d ? DROP : RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= RUN;
            drop_pend_q   <= 1'b0;
            tmo_cnt_q     <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            drop_pend_q   <= drop_pend_d;
            tmo_cnt_q     <= tmo_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign hz.pc_we         = pc_we;
    assign hz.if_id_we      = if_id_we;
    assign hz.if_id_flush   = if_id_flush;
    assign hz.id_ex_we      = id_ex_we;
    assign hz.id_ex_flush   = id_ex_flush;
    assign hz.ex_mem_we     = ex_mem_we;
    assign hz.mem_wb_we     = mem_wb_we;
    assign hz.mem_wb_bubble = mem_wb_bubble;
    assign hz.mem_timeout   = mem_timeout_q;
    assign hz.state_o       = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (!pc_we) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (if_id_flush || id_ex_flush) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT = 5).
// Expected control vectors are queued at drive time and checked mid-cycle.
module tb_pipe_hazard_ctrl;

    logic clock;
    logic reset;

    pipe_hazard_ctrl_if bus();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    pipe_hazard_ctrl #(
        .TMO_W       (8),
        .MEM_TIMEOUT (5)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .hz             (bus.master)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // base order: pc, ifwe, iff, idwe, idf, exwe, mwwe, bub
    localparam logic [7:0] B_RST  = 8'b0010_1001;
    localparam logic [7:0] B_FULL = 8'b1101_0110;
    localparam logic [7:0] B_STL  = 8'b0000_1110;
    localparam logic [7:0] B_JMP  = 8'b1111_0110;
    localparam logic [7:0] B_NRDY = 8'b0011_0110;
    localparam logic [7:0] B_DRP  = 8'b1011_0110;
    localparam logic [7:0] B_HOLD = 8'b0000_0001;

    localparam logic [7:0] M_ALL  = 8'b1111_1111;
    localparam logic [7:0] M_STL  = 8'b1110_1111;
    localparam logic [7:0] M_JMP  = 8'b1011_1111;
    localparam logic [7:0] M_HOLD = 8'b1101_0101;

    typedef struct {
        string       tag;
        logic [10:0] exp;
        logic [10:0] msk;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag,
                        input logic st, input logic jp,
                        input logic bz, input logic vl,
                        input logic rq, input logic dn,
                        input logic [7:0] b, input logic [7:0] m,
                        input logic tmo, input logic [1:0] s);
        exp_t e;
        exp_t x;
        logic [10:0] obs;
        bus.id_stall  = st;
        bus.id_jump   = jp;
        bus.ifu_busy  = bz;
        bus.ifu_valid = vl;
        bus.lsu_req   = rq;
        bus.lsu_done  = dn;
        e.tag = tag;
        e.exp = {b, tmo, s};
        e.msk = {m, 3'b111};
        sb.push_back(e);
        @(negedge clock);
        obs = {bus.pc_we, bus.if_id_we, bus.if_id_flush,
               bus.id_ex_we, bus.id_ex_flush, bus.ex_mem_we,
               bus.mem_wb_we, bus.mem_wb_bubble,
               bus.mem_timeout, bus.state_o};
        x = sb.pop_front();
        chk(x.tag, 32'(obs & x.msk), 32'(x.exp & x.msk));
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 3; i++)
            step("rst", 0,0,0,1,0,0, B_RST, M_ALL, 0, 2'd0);
        reset = 1'b1;
        step("rel",    0,0,0,1,0,0, B_FULL, M_ALL, 0, 2'd0);

        step("stl",    1,0,0,1,0,0, B_STL,  M_STL, 0, 2'd0);
        step("stl_nx", 0,0,0,1,0,0, B_FULL, M_ALL, 0, 2'd0);

        step("stjp",   1,1,0,1,0,0, B_STL,  M_STL, 0, 2'd0);
        step("jp",     0,1,0,1,0,0, B_JMP,  M_JMP, 0, 2'd0);
        step("jp_nx",  0,0,0,1,0,0, B_FULL, M_ALL, 0, 2'd0);

        step("hold0",  0,0,0,1,1,0, B_HOLD, M_HOLD, 0, 2'd0);
        for (int i = 1; i < 4; i++)
            step("hold", 0,0,0,1,1,0, B_HOLD, M_HOLD, 0, 2'd1);
        step("done",   0,0,0,1,1,1, B_FULL, M_ALL, 0, 2'd1);
        step("done_nx",0,0,0,1,0,0, B_FULL, M_ALL, 0, 2'd0);

        step("jb",     0,1,1,0,0,0, B_JMP,  M_JMP, 0, 2'd0);
        step("wait",   0,0,1,0,0,0, B_NRDY, M_JMP, 0, 2'd2);
        step("drp",    0,0,0,1,0,0, B_DRP,  M_JMP, 0, 2'd2);
        step("drp_nx", 0,0,0,1,0,0, B_FULL, M_ALL, 0, 2'd0);

        step("th0",    0,0,0,1,1,0, B_HOLD, M_HOLD, 0, 2'd0);
        for (int i = 1; i < 5; i++)
            step("th",  0,0,0,1,1,0, B_HOLD, M_HOLD, 0, 2'd1);
        step("th_tmo", 0,0,0,1,1,0, B_HOLD, M_HOLD, 1, 2'd1);
        step("tdone",  0,0,0,1,1,1, B_FULL, M_ALL, 1, 2'd1);
        step("tafter", 0,0,0,1,0,0, B_FULL, M_ALL, 1, 2'd0);
        step("tstick", 0,0,0,1,0,0, B_FULL, M_ALL, 1, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
